// File: rtl/crash_judge.sv
// crash_judge -- collision judge for a sprite shooter.
//
// Purpose: checks the player sprite against two enemy sprites every cycle,
// registers the overlap (stage 1) and feeds it to a small game FSM (stage 2)
// that tracks lives, a post-hit freeze window and game over.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start               single-cycle start/restart request (IDLE/OVER only)
//   PLANE_x/y           player sprite top-left corner
//   ENEMY1_x/y          straight-flying enemy top-left corner
//   ENEMY2_x/y          diagonal-flying enemy top-left corner
//   CRASH               1 freezes all enemy movers (any state but PLAY)
//   hit_pulse           one-cycle strobe per accepted collision
//   lives               remaining lives
//   game_over           1 while in OVER
module crash_judge #(
    parameter logic [11:0] PLANE_W       = 12'd64,
    parameter logic [11:0] PLANE_H       = 12'd64,
    parameter logic [11:0] ENEMY_W       = 12'd48,
    parameter logic [11:0] ENEMY_H       = 12'd48,
    parameter logic [1:0]  LIVES_INIT    = 2'd3,
    parameter logic [31:0] INVULN_CYCLES = 32'd50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] PLANE_x,
    input  logic [11:0] PLANE_y,
    input  logic [11:0] ENEMY1_x,
    input  logic [11:0] ENEMY1_y,
    input  logic [11:0] ENEMY2_x,
    input  logic [11:0] ENEMY2_y,
    output logic        CRASH,
    output logic        hit_pulse,
    output logic [1:0]  lives,
    output logic        game_over
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_HIT, S_OVER} state_t;

    state_t      state_q, state_d;
    logic [1:0]  lives_q, lives_d;
    logic [31:0] cnt_q, cnt_d;
    logic        ovl_q, ovl_d;
    logic        hit_q, hit_d;
    logic        crash_q, crash_d;
    logic        go_q, go_d;

    // Box overlap with all sums widened to 13 bits so sprites near the
    // right/bottom edge of the 12-bit space cannot wrap into a false hit.
    function automatic logic overlaps(input logic [11:0] px, input logic [11:0] py,
                                      input logic [11:0] ex, input logic [11:0] ey);
        logic [12:0] ex_end, ey_end, px_end, py_end;
        logic        off;
        ex_end = {1'b0, ex} + {1'b0, ENEMY_W};
        ey_end = {1'b0, ey} + {1'b0, ENEMY_H};
        px_end = {1'b0, px} + {1'b0, PLANE_W};
        py_end = {1'b0, py} + {1'b0, PLANE_H};
        off    = (ex >= 12'd1280) || (ey >= 12'd1024);
        return !off && ({1'b0, px} < ex_end) && ({1'b0, ex} < px_end)
                    && ({1'b0, py} < ey_end) && ({1'b0, ey} < py_end);
    endfunction

    always_comb begin
        ovl_d = overlaps(PLANE_x, PLANE_y, ENEMY1_x, ENEMY1_y)
              | overlaps(PLANE_x, PLANE_y, ENEMY2_x, ENEMY2_y);
    end

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_PLAY;
                lives_d = LIVES_INIT;
                cnt_d   = '0;
            end
            S_PLAY: if (ovl_q) begin
                // Two simultaneous enemy overlaps were already OR-ed in
                // stage 1, so they cost a single life here.
                hit_d = 1'b1;
                if (lives_q > 2'd1) begin
                    state_d = S_HIT;
                    lives_d = lives_q - 2'd1;
                    cnt_d   = INVULN_CYCLES - 32'd1;
                end else begin
                    state_d = S_OVER;
                    lives_d = 2'd0;
                end
            end
            S_HIT: begin
                // Overlap is ignored while frozen; it is judged afresh once
                // back in PLAY.
                if (cnt_q == 32'd0) state_d = S_PLAY;
                else                cnt_d   = cnt_q - 32'd1;
            end
            S_OVER: if (start) begin
                state_d = S_PLAY;
                lives_d = LIVES_INIT;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
        // Level outputs are registered from the next state so they line up
        // with the state they describe.
        crash_d = (state_d != S_PLAY);
        go_d    = (state_d == S_OVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lives_q <= 2'd0;
            cnt_q   <= '0;
            ovl_q   <= 1'b0;
            hit_q   <= 1'b0;
            crash_q <= 1'b1;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
            ovl_q   <= ovl_d;
            hit_q   <= hit_d;
            crash_q <= crash_d;
            go_q    <= go_d;
        end
    end

    assign CRASH     = crash_q;
    assign hit_pulse = hit_q;
    assign lives     = lives_q;
    assign game_over = go_q;

endmodule

// File: tb/tb_crash_judge.sv
// Scoreboard bench for crash_judge: the driver computes the expected
// outputs of every clock edge from a behavioural game model and queues them;
// the monitor pops one entry per cycle and compares against the DUT.
module tb_crash_judge;

    localparam int INV = 16;
    localparam int LI  = 3;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [11:0] px, py, e1x, e1y, e2x, e2y;
    logic        crash, hit_pulse, game_over;
    logic [1:0]  lives;

    crash_judge #(.INVULN_CYCLES(32'd16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .PLANE_x(px), .PLANE_y(py),
        .ENEMY1_x(e1x), .ENEMY1_y(e1y),
        .ENEMY2_x(e2x), .ENEMY2_y(e2y),
        .CRASH(crash), .hit_pulse(hit_pulse), .lives(lives), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit crash;
        bit hit;
        int lives;
        bit go;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Behavioural game model: mode names, a freeze countdown in cycles,
    // a one-cycle-delayed copy of the collision test.
    localparam int M_IDLE = 0, M_PLAY = 1, M_FROZEN = 2, M_OVER = 3;
    int m_mode = M_IDLE, m_lives = 0, m_freeze = 0;
    bit m_seen = 0, m_hit = 0;

    function automatic bit touch(int ax, int ay, int bx, int by);
        if (bx >= 1280 || by >= 1024) return 0;
        return (ax < bx + 48) && (bx < ax + 64) && (ay < by + 48) && (by < ay + 64);
    endfunction

    task automatic model_step();
        exp_t e;
        bit now;
        now = touch(px, py, e1x, e1y) || touch(px, py, e2x, e2y);
        if (rst) begin
            m_mode = M_IDLE; m_lives = 0; m_freeze = 0; m_seen = 0; m_hit = 0;
        end else begin
            m_hit = 0;
            if (m_mode == M_IDLE || m_mode == M_OVER) begin
                if (start) begin m_mode = M_PLAY; m_lives = LI; end
            end else if (m_mode == M_PLAY) begin
                if (m_seen) begin
                    m_hit = 1;
                    m_lives = m_lives - 1;
                    if (m_lives == 0) m_mode = M_OVER;
                    else begin m_mode = M_FROZEN; m_freeze = INV; end
                end
            end else begin
                m_freeze = m_freeze - 1;
                if (m_freeze == 0) m_mode = M_PLAY;
            end
            m_seen = now;
        end
        e.crash = (m_mode != M_PLAY);
        e.hit   = m_hit;
        e.lives = m_lives;
        e.go    = (m_mode == M_OVER);
        exp_q.push_back(e);
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            model_step();
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic park();
        e1x = 12'd2000; e1y = 12'd2000; e2x = 12'd2000; e2y = 12'd2000;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (crash !== e.crash || hit_pulse !== e.hit || game_over !== e.go ||
                lives !== 2'(e.lives)) begin
                n_bad++;
                $display("FAIL outputs cyc=%0d: got CRASH=%b hit=%b lives=%0d go=%b, expected CRASH=%b hit=%b lives=%0d go=%b",
                         cyc, crash, hit_pulse, lives, game_over, e.crash, e.hit, e.lives, e.go);
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0;
        px = 12'd100; py = 12'd100;
        park();
        tick(2);
        rst = 1'b0;
        tick(3);

        // start, then first hit
        start = 1'b1; tick();
        e1x = 12'd130; e1y = 12'd120; tick(3);
        park(); tick(INV + 4);

        // touching vs overlapping on x
        py = 12'd100; e1y = 12'd100; e1x = 12'd164; tick(4);
        e1x = 12'd163; tick(2);
        park(); tick(INV + 4);

        // off-screen and wrap cases
        px = 12'd1250; e2x = 12'd1280; e2y = 12'd100; tick(4);
        px = 12'd4080; e2x = 12'd4090; tick(4);
        e1x = 12'd4090; e1y = 12'd100; tick(4);
        park(); px = 12'd100; tick(2);

        // third hit -> OVER, restart
        e1x = 12'd120; e1y = 12'd110; tick(3);
        park(); tick(5);
        start = 1'b1; tick(); tick(2);

        // both enemies at once, start in HIT ignored, rst mid-HIT
        e1x = 12'd110; e1y = 12'd90; e2x = 12'd90; e2y = 12'd130; tick(2);
        park(); tick(3);
        start = 1'b1; tick(2);
        rst = 1'b1; tick();
        rst = 1'b0; tick(3);

        // randomized play
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 7) == 0) begin
                px = 12'($urandom_range(0, 1300));
                py = 12'($urandom_range(0, 1050));
            end
            if ($urandom_range(0, 1) == 0) begin
                e1x = 12'(int'(px) + $urandom_range(0, 160) - 80);
                e1y = 12'(int'(py) + $urandom_range(0, 160) - 80);
            end else begin
                e1x = 12'($urandom); e1y = 12'($urandom);
            end
            if ($urandom_range(0, 2) == 0) begin
                e2x = 12'(int'(px) + $urandom_range(0, 160) - 80);
                e2y = 12'(int'(py) + $urandom_range(0, 160) - 80);
            end else begin
                e2x = 12'($urandom); e2y = 12'($urandom);
            end
            tick();
        end
        rst = 1'b0; start = 1'b0; park();
        tick(2);
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
